// File: rtl/cpu_periph_pkg.sv
// Shared constants for the CPU peripheral hub: UART framing and RX state encoding.
package cpu_periph_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int DEF_CLKS_PER_BIT = 434;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling FSM, one-cycle push / framing-error pulses.
module uart_rx_core
    import cpu_periph_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uart_in,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_push,
    output logic                   rx_ferr
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic                   sync_p0;
    logic                   sync_p1;
    logic [1:0]             state;
    logic [CNT_W-1:0]       clk_cnt;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shift;
    logic                   half_tick;
    logic                   bit_tick;

    assign half_tick = (clk_cnt == HALF_M1);
    assign bit_tick  = (clk_cnt == FULL_M1);

    // Synchroniser stage: idle-high so a reset does not look like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= uart_in;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RX_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!sync_p1) state <= RX_START;
                end
                RX_START: begin
                    if (half_tick) begin
                        clk_cnt <= '0;
                        state   <= sync_p1 ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        state   <= RX_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // LSB arrives first, so shift in from the top
    always_ff @(posedge clk) begin
        if (state == RX_DATA && bit_tick) shift <= {sync_p1, shift[UART_DATA_W-1:1]};
    end

    assign rx_data = shift;
    assign rx_push = (state == RX_STOP) && bit_tick && sync_p1;
    assign rx_ferr = (state == RX_STOP) && bit_tick && !sync_p1;

endmodule

// File: rtl/cpu_periph_hub.sv
// CPU-side peripheral hub: UART RX into a show-ahead FIFO with threshold interrupt,
// sticky overflow/framing flags and a CPU-writable LED register.
module cpu_periph_hub
    import cpu_periph_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int INT_THRESH   = 1,
    parameter int LED_W        = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_in,
    output logic                          int0,
    output logic [UART_DATA_W-1:0]        uart_read_byte,
    output logic                          rx_valid,
    input  logic                          cpu_end_read,
    input  logic                          leds_write,
    input  logic [LED_W-1:0]              leds_write_byte,
    output logic [LED_W-1:0]              leds,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clr_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_push;
    logic                   rx_ferr;

    logic [UART_DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic                   full;
    logic                   pop_ok;
    logic                   push_ok;
    logic                   ovf_set;
    logic [CNT_W-1:0]       count_nxt;
    logic [UART_DATA_W-1:0] head_nxt;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .uart_in (uart_in),
        .rx_data (rx_data),
        .rx_push (rx_push),
        .rx_ferr (rx_ferr)
    );

    // A pop in the same cycle frees the slot a full-FIFO push needs
    assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop_ok    = cpu_end_read && (fifo_count != '0);
    assign push_ok   = rx_push && (!full || pop_ok);
    assign ovf_set   = rx_push && full && !pop_ok;
    assign count_nxt = fifo_count + CNT_W'(push_ok) - CNT_W'(pop_ok);

    always_comb begin
        head_nxt = uart_read_byte;
        if (pop_ok) begin
            if (fifo_count > CNT_W'(1)) head_nxt = mem[rd_ptr + PTR_W'(1)];
            else if (push_ok)           head_nxt = rx_data;
        end else if (push_ok && fifo_count == '0) begin
            head_nxt = rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fifo_count     <= '0;
            rx_valid       <= 1'b0;
            int0           <= 1'b0;
            uart_read_byte <= '0;
            overflow       <= 1'b0;
            frame_err      <= 1'b0;
            leds           <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count     <= count_nxt;
            rx_valid       <= (count_nxt != '0);
            int0           <= (count_nxt >= CNT_W'(INT_THRESH));
            uart_read_byte <= head_nxt;
            overflow       <= ovf_set | (overflow  & ~clr_err);
            frame_err      <= rx_ferr | (frame_err & ~clr_err);
            if (leds_write) leds <= leds_write_byte;
        end
    end

endmodule
